// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with per-entry saturating direction counters,
// round-robin replacement and a one-set-per-cycle flush sweep.
module btb_assoc #(
   parameter int NUM_SETS = 64,
   parameter int NUM_WAYS = 2,
   parameter int CTR_BITS = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] lookup_pc,
   output logic        hit,
   output logic        taken,
   output logic [31:0] target_addr,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic [31:0] upd_target,
   input  logic        upd_taken,
   input  logic        flush_req,
   output logic        busy
);

   localparam int IW = $clog2(NUM_SETS);
   localparam int TW = 30 - IW;
   localparam int WW = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
   localparam logic [CTR_BITS-1:0] CTR_WEAK_TAKEN = CTR_BITS'(1) << (CTR_BITS - 1);

   typedef enum logic {IDLE, FLUSH} state_t;

   state_t        state, state_nxt;
   logic [IW-1:0] sweep, sweep_nxt;

   logic [NUM_WAYS-1:0] valid   [NUM_SETS];
   logic [CTR_BITS-1:0] ctr     [NUM_SETS][NUM_WAYS];
   logic [TW-1:0]       tag_mem [NUM_SETS][NUM_WAYS];
   logic [31:0]         tgt_mem [NUM_SETS][NUM_WAYS];
   logic [WW-1:0]       rr      [NUM_SETS];

   logic [IW-1:0] lk_idx, up_idx;
   logic [TW-1:0] lk_tag, up_tag;
   logic          lk_hit, up_hit, have_inv, do_upd;
   logic [WW-1:0] up_way, victim;
   logic          unused_pc_bits;

   function automatic logic [CTR_BITS-1:0] sat_inc(input logic [CTR_BITS-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   function automatic logic [CTR_BITS-1:0] sat_dec(input logic [CTR_BITS-1:0] c);
      return (c == '0) ? c : c - 1'b1;
   endfunction

   function automatic logic [WW-1:0] next_rr(input logic [WW-1:0] p);
      return (NUM_WAYS == 1) ? '0 : p + 1'b1;
   endfunction

   assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};
   assign lk_idx = lookup_pc[IW+1:2];
   assign lk_tag = lookup_pc[31:IW+2];
   assign up_idx = upd_pc[IW+1:2];
   assign up_tag = upd_pc[31:IW+2];
   assign busy   = (state == FLUSH);
   // flush_req wins over a same-cycle update
   assign do_upd = (state == IDLE) && upd_valid && !flush_req;

   always_comb begin
      lk_hit      = 1'b0;
      taken       = 1'b0;
      target_addr = 32'h0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (!lk_hit && state == IDLE && valid[lk_idx][w] && tag_mem[lk_idx][w] == lk_tag) begin
            lk_hit      = 1'b1;
            taken       = ctr[lk_idx][w][CTR_BITS-1];
            target_addr = tgt_mem[lk_idx][w];
         end
      end
      hit = lk_hit;
   end

   always_comb begin
      up_hit   = 1'b0;
      up_way   = '0;
      have_inv = 1'b0;
      victim   = rr[up_idx];
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (!up_hit && valid[up_idx][w] && tag_mem[up_idx][w] == up_tag) begin
            up_hit = 1'b1;
            up_way = WW'(w);
         end
         if (!have_inv && !valid[up_idx][w]) begin
            have_inv = 1'b1;
            victim   = WW'(w);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      sweep_nxt = sweep;
      case (state)
         IDLE: begin
            if (flush_req) begin
               state_nxt = FLUSH;
               sweep_nxt = '0;
            end
         end
         FLUSH: begin
            sweep_nxt = sweep + 1'b1;
            if (sweep == IW'(NUM_SETS - 1)) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         sweep <= '0;
         for (int s = 0; s < NUM_SETS; s++) begin
            valid[s] <= '0;
            rr[s]    <= '0;
            for (int w = 0; w < NUM_WAYS; w++) ctr[s][w] <= '0;
         end
      end else begin
         state <= state_nxt;
         sweep <= sweep_nxt;
         if (state == FLUSH) begin
            valid[sweep] <= '0;
            rr[sweep]    <= '0;
         end else if (do_upd) begin
            if (up_hit) begin
               ctr[up_idx][up_way] <= upd_taken ? sat_inc(ctr[up_idx][up_way])
                                                : sat_dec(ctr[up_idx][up_way]);
            end else if (upd_taken) begin
               valid[up_idx][victim] <= 1'b1;
               ctr[up_idx][victim]   <= CTR_WEAK_TAKEN;
               if (!have_inv) rr[up_idx] <= next_rr(victim);
            end
         end
      end
   end

   // tag/target contents are meaningless while invalid, so they carry no reset
   always_ff @(posedge clk) begin
      if (do_upd && upd_taken) begin
         if (up_hit) begin
            tgt_mem[up_idx][up_way] <= upd_target;
         end else begin
            tag_mem[up_idx][victim] <= up_tag;
            tgt_mem[up_idx][victim] <= upd_target;
         end
      end
   end

endmodule

// File: tb/tb_btb_assoc.sv
// Scoreboard bench for btb_assoc: stimulus queues expected lookup results,
// a negedge monitor pops and compares them while the probe strobe is high.
module tb_btb_assoc;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] lookup_pc;
   logic        hit, taken, busy;
   logic [31:0] target_addr;
   logic        upd_valid, upd_taken, flush_req;
   logic [31:0] upd_pc, upd_target;
   logic        probe;

   typedef struct {
      logic        h;
      logic        t;
      logic [31:0] a;
      logic        b;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   btb_assoc #(.NUM_SETS(64), .NUM_WAYS(2), .CTR_BITS(2)) dut (
      .clk(clk), .rst_n(rst_n), .lookup_pc(lookup_pc), .hit(hit), .taken(taken),
      .target_addr(target_addr), .upd_valid(upd_valid), .upd_pc(upd_pc),
      .upd_target(upd_target), .upd_taken(upd_taken), .flush_req(flush_req), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (probe) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: probe with no expected entry");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if ({hit, taken, target_addr, busy} !== {e.h, e.t, e.a, e.b}) begin
               errors++;
               $display("FAIL %s: got hit=%0b taken=%0b tgt=%h busy=%0b, expected hit=%0b taken=%0b tgt=%h busy=%0b",
                        e.name, hit, taken, target_addr, busy, e.h, e.t, e.a, e.b);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input logic [31:0] pc, input logic h, input logic t,
                      input logic [31:0] a, input logic b, input string name);
      exp_t e;
      e.h = h; e.t = t; e.a = a; e.b = b; e.name = name;
      exp_q.push_back(e);
      lookup_pc = pc;
      probe     = 1'b1;
      step();
      probe     = 1'b0;
   endtask

   task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
      upd_valid  = 1'b1;
      upd_pc     = pc;
      upd_target = tgt;
      upd_taken  = tk;
      step();
      upd_valid  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; lookup_pc = 32'h0; upd_valid = 1'b0; upd_pc = 32'h0;
      upd_target = 32'h0; upd_taken = 1'b0; flush_req = 1'b0; probe = 1'b0;
      step(); step();
      rst_n = 1'b1;

      chk(32'h100, 0, 0, 32'h0, 0, "reset_state");

      // allocate then look up
      upd(32'h100, 32'h200, 1'b1);
      chk(32'h100, 1, 1, 32'h200, 0, "alloc_hit");
      chk(32'h104, 0, 0, 32'h0, 0, "neighbour_miss");

      // counter: 2 -> 1 -> 0 -> 0, target kept on not-taken
      upd(32'h100, 32'h999, 1'b0);
      chk(32'h100, 1, 0, 32'h200, 0, "ctr_dec1");
      upd(32'h100, 32'h999, 1'b0);
      upd(32'h100, 32'h999, 1'b0);
      chk(32'h100, 1, 0, 32'h200, 0, "ctr_sat_low");
      // 0 -> 1 -> 2 -> 3 -> 3, taken updates rewrite target
      upd(32'h100, 32'h240, 1'b1);
      chk(32'h100, 1, 0, 32'h240, 0, "ctr_inc1");
      upd(32'h100, 32'h240, 1'b1);
      chk(32'h100, 1, 1, 32'h240, 0, "ctr_inc2");
      upd(32'h100, 32'h240, 1'b1);
      upd(32'h100, 32'h280, 1'b1);
      chk(32'h100, 1, 1, 32'h280, 0, "ctr_sat_high");
      // one not-taken from saturated stays taken (3 -> 2)
      upd(32'h100, 32'h0, 1'b0);
      chk(32'h100, 1, 1, 32'h280, 0, "ctr_hyst");

      // not-taken miss does not allocate
      upd(32'h500, 32'h600, 1'b0);
      chk(32'h500, 0, 0, 32'h0, 0, "no_alloc_nt");

      // same-set replacement: 0x100 way0, 0x200 way1, 0x300 evicts way0
      upd(32'h200, 32'h2000, 1'b1);
      upd(32'h300, 32'h3000, 1'b1);
      chk(32'h100, 0, 0, 32'h0, 0, "evict_100");
      chk(32'h200, 1, 1, 32'h2000, 0, "keep_200");
      chk(32'h300, 1, 1, 32'h3000, 0, "alloc_300");
      // round-robin pointer now at way1
      upd(32'h100, 32'h1000, 1'b1);
      chk(32'h200, 0, 0, 32'h0, 0, "rr_evict_200");
      chk(32'h300, 1, 1, 32'h3000, 0, "rr_keep_300");
      chk(32'h100, 1, 1, 32'h1000, 0, "rr_alloc_100");

      // flush with simultaneous update, updates and re-requests ignored during sweep
      flush_req = 1'b1; upd_valid = 1'b1; upd_pc = 32'h400; upd_target = 32'h4400; upd_taken = 1'b1;
      step();
      for (int i = 0; i < 64; i++) chk(32'h300, 0, 0, 32'h0, 1, $sformatf("flush_busy_%0d", i));
      flush_req = 1'b0; upd_valid = 1'b0;
      chk(32'h300, 0, 0, 32'h0, 0, "flush_done");
      chk(32'h100, 0, 0, 32'h0, 0, "flush_miss_100");
      chk(32'h400, 0, 0, 32'h0, 0, "flush_upd_ignored");
      upd(32'h104, 32'h700, 1'b1);
      chk(32'h104, 1, 1, 32'h700, 0, "post_flush_alloc");

      // reset mid-flush; set 63 entry not yet swept must still be cleared
      upd(32'h1FC, 32'h800, 1'b1);
      chk(32'h1FC, 1, 1, 32'h800, 0, "alloc_set63");
      flush_req = 1'b1;
      step();
      flush_req = 1'b0;
      for (int i = 0; i < 10; i++) chk(32'h1FC, 0, 0, 32'h0, 1, $sformatf("flush2_busy_%0d", i));
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk(32'h1FC, 0, 0, 32'h0, 0, "rst_mid_flush_63");
      chk(32'h104, 0, 0, 32'h0, 0, "rst_mid_flush_104");

      step();
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/btb_assoc.md
BTB_ASSOC -- requirements
Module: btb_assoc

Interface
REQ-001 SHALL have parameter NUM_SETS, default 64, meaning number of sets; it is a power of 2 and at least 2.
REQ-002 SHALL have parameter NUM_WAYS, default 2, meaning ways per set; legal values are 1, 2 and 4.
REQ-003 SHALL have parameter CTR_BITS, default 2, meaning width of the per-entry saturating direction counter; it is at least 1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port lookup_pc, input, 32 bits: fetch PC to predict.
REQ-007 SHALL have port hit, output, 1 bit: lookup_pc matches a valid entry.
REQ-008 SHALL have port taken, output, 1 bit: predicted taken.
REQ-009 SHALL have port target_addr, output, 32 bits: predicted target.
REQ-010 SHALL have port upd_valid, input, 1 bit: resolved branch update strobe.
REQ-011 SHALL have port upd_pc, input, 32 bits: PC of the resolved branch.
REQ-012 SHALL have port upd_target, input, 32 bits: resolved target.
REQ-013 SHALL have port upd_taken, input, 1 bit: resolved direction.
REQ-014 SHALL have port flush_req, input, 1 bit: single-cycle request to invalidate all entries.
REQ-015 SHALL have port busy, output, 1 bit: flush sweep in progress.

Function
REQ-016 SHALL set index = PC[IW+1:2] and tag = PC[31:IW+2], where IW = log2(NUM_SETS); PC[1:0] is ignored.
REQ-017 SHALL compute hit combinationally, with no cycle latency: hit = any way in the indexed set is valid with a matching tag, and state is not FLUSH.
REQ-018 SHALL drive taken = hit AND the MSB of the hitting entry's counter.
REQ-019 SHALL drive target_addr = the hitting entry's target, and 32'h0 when hit = 0.
REQ-020 SHALL make the lookup observe pre-edge state; an update on the same edge to the same set is visible only on the next cycle.
REQ-021 SHALL, on upd_valid with upd_pc hitting way w (while IDLE): increment w's counter if upd_taken, else decrement it; saturate at all-ones and at 0; overwrite w's target with upd_target only when upd_taken.
REQ-022 SHALL, on upd_valid with an upd_pc miss and upd_taken = 1, allocate an entry: set valid, write tag and target, and initialise the counter to weakly taken (MSB = 1, other bits 0).
REQ-023 SHALL choose the victim as the lowest-numbered invalid way; if the set is full, choose the set's round-robin pointer way and then advance the pointer modulo NUM_WAYS.
REQ-024 SHALL not allocate on an upd_valid miss with upd_taken = 0; state is unchanged.
REQ-025 SHALL guarantee at most one way per set ever matches a given tag, since allocation occurs only on a miss.
REQ-026 SHALL implement the FSM states IDLE and FLUSH.
REQ-027 SHALL, on flush_req in IDLE, enter FLUSH on the next edge with sweep counter = 0 and busy = 1.
REQ-028 SHALL, in FLUSH, clear the valid bits and the round-robin pointer of set[counter] on each edge, then increment the counter.
REQ-029 SHALL, after clearing set NUM_SETS-1, return to IDLE; busy is therefore high for exactly NUM_SETS cycles.
REQ-030 SHALL, in FLUSH, force hit = 0, taken = 0 and target_addr = 0, and ignore upd_valid and flush_req.
REQ-031 SHALL give flush_req priority over upd_valid when both are asserted in IDLE on the same cycle; the update is dropped.

Reset
REQ-032 SHALL, when rst_n = 0 at a rising edge, clear all valid bits, counters, round-robin pointers and the sweep counter, and set state = IDLE; this also applies mid-FLUSH.
REQ-033 SHALL, after reset, produce hit = 0, taken = 0, target_addr = 0 and busy = 0.
REQ-034 SHALL reset tag and target arrays to 0 only if that is cheap; their values are don't-care while the entry is invalid.

Verification
REQ-035 SHALL verify: after reset, lookup_pc = 0x100 gives hit = 0, taken = 0, target_addr = 0, busy = 0.
REQ-036 SHALL verify: update pc 0x100, target 0x200, taken, then the next cycle lookup 0x100 gives hit = 1, taken = 1, target 0x200; lookup 0x104 gives hit = 0.
REQ-037 SHALL verify: 3 not-taken updates to 0x100 leave the counter at 0 and taken = 0 while hit = 1; then 4 taken updates leave the counter at 3 and taken = 1 (CTR_BITS = 2).
REQ-038 SHALL verify, with NUM_SETS = 64 and NUM_WAYS = 2: allocate 0x100, 0x200, 0x300 (same set) taken; 0x100 is evicted, while 0x200 and 0x300 hit.
REQ-039 SHALL verify: flush_req gives busy = 1 for 64 cycles with hit = 0 throughout, updates are ignored, and after that all prior entries miss.
REQ-040 SHALL verify: rst_n = 0 at flush cycle 10 gives busy = 0 the next cycle, and all lookups miss.
